// File: rtl/guard_patrol_sequencer.sv
// Patrol sequencer for one guard sprite: walks a closed rectangle with holds between legs,
// drops into ALERT on a player sighting and resumes the interrupted leg afterwards.
//
// state  | meaning
// -------+---------------------------------------------
// START  | parked at reset position, waiting for first tick
// UP     | move leg, Y decreases
// HOLD1  | pause after UP
// RIGHT  | move leg, X increases
// HOLD2  | pause after RIGHT
// DOWN   | move leg, Y increases
// HOLD3  | pause after DOWN
// LEFT   | move leg, X decreases
// HOLD4  | pause after LEFT, then back to UP
// ALERT  | frozen, counting ticks since the last sighting
module guard_patrol_sequencer #(
  parameter int START_X     = 100,
  parameter int START_Y     = 200,
  parameter int LEG_TICKS   = 64,
  parameter int HOLD_TICKS  = 32,
  parameter int ALERT_TICKS = 120,
  parameter int SPEED       = 1,
  parameter int SIZE        = 16,
  parameter int VLEN        = 64,
  parameter int VHALF       = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       i_tick,
  input  logic       i_enable,
  input  logic       i_player_seen,
  output logic [9:0] o_GuardX,
  output logic [9:0] o_GuardY,
  output logic [2:0] o_direction_guard,
  output logic [2:0] o_facing,
  output logic [9:0] o_vision_startX,
  output logic [9:0] o_vision_startY,
  output logic [9:0] o_vision_endX,
  output logic [9:0] o_vision_endY,
  output logic       o_alert
);

  typedef enum logic [3:0] {
    S_START, S_UP, S_HOLD1, S_RIGHT, S_HOLD2,
    S_DOWN, S_HOLD3, S_LEFT, S_HOLD4, S_ALERT
  } state_t;

  localparam logic [2:0] D_IDLE  = 3'd0;
  localparam logic [2:0] D_UP    = 3'd1;
  localparam logic [2:0] D_DOWN  = 3'd2;
  localparam logic [2:0] D_LEFT  = 3'd3;
  localparam logic [2:0] D_RIGHT = 3'd4;

  localparam logic [9:0]  C_START_X = 10'(START_X);
  localparam logic [9:0]  C_START_Y = 10'(START_Y);
  localparam logic [9:0]  C_SPEED   = 10'(SPEED);
  localparam logic [15:0] C_LEG_TC  = 16'(LEG_TICKS - 1);
  localparam logic [15:0] C_HOLD_TC = 16'(HOLD_TICKS - 1);
  localparam logic [15:0] C_ALRT_TC = 16'(ALERT_TICKS - 1);

  localparam logic signed [10:0] C_VH   = 11'(VHALF);
  localparam logic signed [10:0] C_VL   = 11'(VLEN);
  localparam logic signed [10:0] C_SZ   = 11'(SIZE);
  localparam logic signed [10:0] C_SIDE = 11'(SIZE - 1 + VHALF);
  localparam logic signed [10:0] C_FAR  = 11'(SIZE - 1 + VLEN);
  localparam logic signed [10:0] C_XMAX = 11'sd639;
  localparam logic signed [10:0] C_YMAX = 11'sd479;

  function automatic logic [9:0] f_clamp(input logic signed [10:0] v,
                                         input logic signed [10:0] vmax);
    if (v < 11'sd0) return 10'd0;
    if (v > vmax)   return vmax[9:0];
    return v[9:0];
  endfunction

  // Packed as {startX, startY, endX, endY}
  function automatic logic [39:0] f_box(input logic [9:0] gx, input logic [9:0] gy,
                                        input logic [2:0] fc);
    logic signed [10:0] sx, sy, x0, x1, y0, y1;
    sx = signed'({1'b0, gx});
    sy = signed'({1'b0, gy});
    x0 = sx - C_VH;
    x1 = sx + C_SIDE;
    y0 = sy - C_VL;
    y1 = sy - 11'sd1;
    case (fc)
      D_DOWN: begin
        y0 = sy + C_SZ;
        y1 = sy + C_FAR;
      end
      D_LEFT: begin
        x0 = sx - C_VL;
        x1 = sx - 11'sd1;
        y0 = sy - C_VH;
        y1 = sy + C_SIDE;
      end
      D_RIGHT: begin
        x0 = sx + C_SZ;
        x1 = sx + C_FAR;
        y0 = sy - C_VH;
        y1 = sy + C_SIDE;
      end
      default: ;
    endcase
    return {f_clamp(x0, C_XMAX), f_clamp(y0, C_YMAX),
            f_clamp(x1, C_XMAX), f_clamp(y1, C_YMAX)};
  endfunction

  function automatic state_t f_next(input state_t s);
    case (s)
      S_UP:    return S_HOLD1;
      S_HOLD1: return S_RIGHT;
      S_RIGHT: return S_HOLD2;
      S_HOLD2: return S_DOWN;
      S_DOWN:  return S_HOLD3;
      S_HOLD3: return S_LEFT;
      S_LEFT:  return S_HOLD4;
      default: return S_UP;
    endcase
  endfunction

  function automatic logic [2:0] f_dir(input state_t s);
    case (s)
      S_UP:    return D_UP;
      S_RIGHT: return D_RIGHT;
      S_DOWN:  return D_DOWN;
      S_LEFT:  return D_LEFT;
      default: return D_IDLE;
    endcase
  endfunction

  state_t      r_state;
  state_t      r_saved_state;
  logic [15:0] r_tick_cnt;
  logic [15:0] r_saved_cnt;
  logic [15:0] r_alert_cnt;
  logic [9:0]  r_GuardX;
  logic [9:0]  r_GuardY;
  logic [2:0]  r_dir;
  logic [2:0]  r_facing;
  logic        r_alert;
  logic [39:0] r_vis;

  logic        w_act;
  logic [39:0] w_box;

  assign w_act = i_tick & i_enable;
  assign w_box = f_box(r_GuardX, r_GuardY, r_facing);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= S_START;
      r_saved_state <= S_START;
      r_tick_cnt    <= '0;
      r_saved_cnt   <= '0;
      r_alert_cnt   <= '0;
      r_GuardX      <= C_START_X;
      r_GuardY      <= C_START_Y;
      r_dir         <= D_IDLE;
      r_facing      <= D_UP;
      r_alert       <= 1'b0;
      r_vis         <= f_box(C_START_X, C_START_Y, D_UP);
    end else begin
      r_vis <= w_box;
      // A sighting outranks any tick in the same cycle; re-sighting only restarts the timeout.
      if (i_player_seen && r_state != S_START) begin
        r_alert_cnt <= '0;
        if (r_state != S_ALERT) begin
          r_saved_state <= r_state;
          r_saved_cnt   <= r_tick_cnt;
          r_state       <= S_ALERT;
          r_dir         <= D_IDLE;
          r_alert       <= 1'b1;
        end
      end else if (w_act) begin
        case (r_state)
          S_START: begin
            r_state    <= S_UP;
            r_dir      <= D_UP;
            r_facing   <= D_UP;
            r_tick_cnt <= '0;
          end
          S_UP, S_RIGHT, S_DOWN, S_LEFT: begin
            case (r_state)
              S_UP:    r_GuardY <= r_GuardY - C_SPEED;
              S_RIGHT: r_GuardX <= r_GuardX + C_SPEED;
              S_DOWN:  r_GuardY <= r_GuardY + C_SPEED;
              default: r_GuardX <= r_GuardX - C_SPEED;
            endcase
            if (r_tick_cnt == C_LEG_TC) begin
              r_tick_cnt <= '0;
              r_state    <= f_next(r_state);
              r_dir      <= D_IDLE;
            end else begin
              r_tick_cnt <= r_tick_cnt + 16'd1;
            end
          end
          S_HOLD1, S_HOLD2, S_HOLD3, S_HOLD4: begin
            if (r_tick_cnt == C_HOLD_TC) begin
              r_tick_cnt <= '0;
              r_state    <= f_next(r_state);
              r_dir      <= f_dir(f_next(r_state));
              r_facing   <= f_dir(f_next(r_state));
            end else begin
              r_tick_cnt <= r_tick_cnt + 16'd1;
            end
          end
          S_ALERT: begin
            if (r_alert_cnt == C_ALRT_TC) begin
              r_state     <= r_saved_state;
              r_tick_cnt  <= r_saved_cnt;
              r_dir       <= f_dir(r_saved_state);
              r_alert     <= 1'b0;
              r_alert_cnt <= '0;
            end else begin
              r_alert_cnt <= r_alert_cnt + 16'd1;
            end
          end
          default: r_state <= S_START;
        endcase
      end
    end
  end

  assign o_GuardX          = r_GuardX;
  assign o_GuardY          = r_GuardY;
  assign o_direction_guard = r_dir;
  assign o_facing          = r_facing;
  assign o_alert           = r_alert;
  assign o_vision_startX   = r_vis[39:30];
  assign o_vision_startY   = r_vis[29:20];
  assign o_vision_endX     = r_vis[19:10];
  assign o_vision_endY     = r_vis[9:0];

endmodule
